uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Byte FIFO between the UART receiver output (DataOut/DataOutValid/DataOutReady) and the CPU's memory-mapped UART load path.
- Absorbs bursts while the CPU is busy, so received bytes are not lost between polls of the receive-data address.
- Presents first-word-fall-through data to the CPU's stage-2 UART decode.
- Honours the CPU pipeline stall, so a pop commits only when the load commits.

Parameters:
- DEPTH, 8: number of byte entries; power of two, at least 2.
- WIDTH, 8: data width in bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset, sampled on posedge clk
- in_data  in  WIDTH  byte from UART receiver
- in_valid  in  1  UART byte available (UART DataOutValid)
- in_ready  out  1  FIFO can accept a byte (drives UART DataOutReady)
- out_data  out  WIDTH  head-of-queue byte
- out_valid  out  1  FIFO non-empty (CPU receive-status bit)
- out_ready  in  1  CPU load of receive-data address in stage 2
- stall  in  1  CPU pipeline stall; blocks the pop when high
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: write pointer = 0, read pointer = 0, count = 0, out_valid = 0.
  - in_ready = 0 while rst is high, and 1 in the first cycle after rst deasserts.
  - out_data is don't-care while out_valid = 0; the bench must not check it.
- Push condition: push = in_valid & in_ready.
  - Write mem[wptr] <= in_data, then wptr <= wptr+1, modulo DEPTH.
- Pop condition: pop = out_valid & out_ready & !stall. Then rptr <= rptr+1, modulo DEPTH.
- Occupancy and flags:
  - count <= count + push - pop.
  - in_ready = (count != DEPTH) & !rst.
  - out_valid = (count != 0).
  - All three are derived combinationally from registered count.
- Head data: out_data = mem[rptr], a combinational read of registered storage (first-word-fall-through).
- Latency: a byte pushed at edge N is visible on out_data with out_valid = 1 after edge N. There is no bypass when empty.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count is unchanged.
- Boundary cases:
  - Full: in_ready = 0, and a same-cycle pop does not enable a push. The UART holds its byte until the next cycle.
  - Empty: pop is impossible; out_ready is ignored.
- Stall: while stall = 1, no pop takes place regardless of out_ready. Pushes continue.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count only.
- Reset mid-operation: contents are discarded, pointers and count return to 0, and storage is not cleared.

Optional Feature:
- Macro: UART_RX_FIFO_OVF_EN.
- When defined, the block adds two ports:
  - ovf  out  1: sticky overflow flag, reset 0. Set on the edge where in_valid = 1 and count == DEPTH.
  - ovf_clr  in  1: clears ovf on the next edge. If set and clear coincide, set wins.
- When not defined, neither port exists and there is no overflow state. Behaviour is otherwise identical.

Decomposition:
- Shared package uart_pkg holds:
  - UART_RX_FIFO_DEPTH = 8.
  - UART_DATA_W = 8.
  - Pointer and count width functions derived with $clog2.
  - Memory-map constants for the receive-data and receive-status addresses in the 0x8000_xxxx UART region, shared with the CPU's UART decode.
- Sub-module uart_rx_fifo_mem:
  - DEPTH x WIDTH register array with one synchronous write port and one combinational read port.
  - The top level holds pointers, count and handshake logic.

Test Plan:
- Reset then idle: hold rst 2 cycles, release -> count = 0, out_valid = 0; in_ready = 0 during rst and 1 on the first cycle after.
- Single byte: push 0x5A at edge N -> after edge N, out_valid = 1, out_data = 0x5A, count = 1; then out_ready = 1, stall = 0 for one cycle -> count = 0, out_valid = 0.
- Fill and drain with wrap: push 0x01..0x08, confirm in_ready = 0 and count = 8; then push/pop 0x09..0x14 concurrently at full-1 -> output order 0x01..0x14 with no loss and count constant during the overlap.
- Stall hold: count = 3, head 0xA1, out_ready = 1 with stall = 1 for 4 cycles while pushing 0xB2 -> head remains 0xA1 and count reaches 4; release stall -> pops resume in order.
- Full blocking: count = 8, in_valid = 1 and a same-cycle pop -> no push that cycle, count = 7; the held byte is pushed the next cycle, count = 8.
- With UART_RX_FIFO_OVF_EN: in_valid = 1 at count = 8 -> ovf = 1 next cycle and stays set; ovf_clr pulse -> ovf = 0; clear coinciding with a new overflow -> ovf = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FIFO sizing, pointer/count width helpers,
// and the memory-map addresses used by the CPU's UART decode.
package uart_pkg;

  localparam int UART_RX_FIFO_DEPTH = 8;
  localparam int UART_DATA_W        = 8;

  // UART region, decoded by the CPU in stage 2
  localparam logic [31:0] UART_RX_STATUS_ADDR = 32'h8000_0000;
  localparam logic [31:0] UART_RX_DATA_ADDR   = 32'h8000_0004;

  // Pointer width: wraps naturally modulo a power-of-two depth
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Count width: must hold 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register-array storage for the UART receive FIFO: one synchronous write
// port, one combinational read port. Contents are never reset.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [ptr_w(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]          wdata_i,
  input  logic [ptr_w(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]          rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the incoming byte into the addressed slot
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Head read is combinational so data falls through to the CPU
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: buffers bytes from the UART receiver until the CPU's
// stage-2 load of the receive-data address commits (pop held off by stall).
// First-word-fall-through head; full/empty are decided by count alone.
// Optional sticky overflow flag (ovf/ovf_clr) when UART_RX_FIFO_OVF_EN is defined.
//
// Handshake: a transfer happens on a posedge where valid and ready are both
// high; valid may not depend on ready, and in_ready/out_valid depend only on
// registered count (plus rst for in_ready).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     stall,
`ifdef UART_RX_FIFO_OVF_EN
  output logic                     ovf,
  input  logic                     ovf_clr,
`endif
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Flags come from registered count; in_ready is forced low during reset
  assign in_ready  = (count_q != FULL_CNT) & ~rst;
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready & ~stall;

  // Next-state for pointers and occupancy
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; storage itself is left untouched by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

`ifdef UART_RX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a byte offered while full sets it; set beats clear
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid && (count_q == FULL_CNT)) ovf_d = 1'b1;
    else if (ovf_clr)                       ovf_d = 1'b0;
  end

  // Overflow flag register
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (in_data),
    .raddr_i (rptr_q),
    .rdata_o (out_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed stimulus, scoreboard queue of expected
// bytes, and a monitor that checks flags and popped data every cycle.
// Build with +define+UART_RX_FIFO_OVF_EN to also exercise the overflow flag.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             stall;
  logic [CW-1:0]    count;
`ifdef UART_RX_FIFO_OVF_EN
  logic             ovf;
  logic             ovf_clr;
`endif

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stall     (stall),
`ifdef UART_RX_FIFO_OVF_EN
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
`endif
    .count     (count)
  );

  // ---------------- scoreboard state ----------------
  logic [WIDTH-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt    = 0;
  bit m_ovf    = 1'b0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  // Samples mid-cycle; predicts what the next posedge will do and checks data on pops.
  always @(negedge clk) begin
    if (mon_en) begin
      bit e_push, e_pop;
      e_push = in_valid && !rst && (m_cnt != DEPTH);
      e_pop  = !rst && out_ready && !stall && (m_cnt != 0);
      chk("mon_count",     32'(count),     32'(m_cnt));
      chk("mon_in_ready",  32'(in_ready),  32'(!rst && (m_cnt != DEPTH)));
      chk("mon_out_valid", 32'(out_valid), 32'(m_cnt != 0));
`ifdef UART_RX_FIFO_OVF_EN
      chk("mon_ovf", 32'(ovf), 32'(m_ovf));
      if (rst)                             m_ovf = 1'b0;
      else if (in_valid && m_cnt == DEPTH) m_ovf = 1'b1;
      else if (ovf_clr)                    m_ovf = 1'b0;
`endif
      if (e_pop) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mon_pop_empty_q: got 0x%0h expected no pop", out_data);
        end else begin
          chk("mon_out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      if (e_push) exp_q.push_back(in_data);
      if (rst) begin
        m_cnt = 0;
        exp_q.delete();
      end else begin
        m_cnt = m_cnt + int'(e_push) - int'(e_pop);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [WIDTH-1:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) step();
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0;
`ifdef UART_RX_FIFO_OVF_EN
    ovf_clr = 1'b0;
`endif
    // Reset then idle
    step();
    mon_en = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_out_valid",32'(out_valid),32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // Single byte
    push_byte(8'h5A);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data",  32'(out_data),  32'h5A);
    chk("single_count", 32'(count),     32'd1);
    drain(1);
    chk("single_count0", 32'(count),     32'd0);
    chk("single_valid0", 32'(out_valid), 32'd0);

    // Fill and drain with wrap
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    chk("fill_count",    32'(count),    32'd8);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    drain(1);
    chk("fill_count7", 32'(count), 32'd7);
    out_ready = 1'b1;
    for (int v = 9; v <= 20; v++) begin
      in_valid = 1'b1;
      in_data  = 8'(v);
      step();
      chk("overlap_count", 32'(count), 32'd7);
    end
    in_valid = 1'b0;
    drain(7);
    chk("wrap_drain_count", 32'(count), 32'd0);

    // Stall hold
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    chk("stall_pre_count", 32'(count), 32'd3);
    out_ready = 1'b1;
    stall     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hB2;
    step();
    in_valid  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_head", 32'(out_data), 32'hA1);
      step();
    end
    chk("stall_head_last", 32'(out_data), 32'hA1);
    chk("stall_count",     32'(count),    32'd4);
    stall = 1'b0;
    drain(4);
    chk("stall_drain_count", 32'(count), 32'd0);

    // Full blocking
    for (int i = 0; i < 8; i++) push_byte(8'hC0 + 8'(i));
    in_valid  = 1'b1;
    in_data   = 8'hD0;
    out_ready = 1'b1;
    step();
    chk("full_pop_count", 32'(count), 32'd7);
    out_ready = 1'b0;
    step();
    in_valid  = 1'b0;
    chk("full_held_push_count", 32'(count), 32'd8);

`ifdef UART_RX_FIFO_OVF_EN
    chk("ovf_set", 32'(ovf), 32'd1);
    step();
    chk("ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    chk("ovf_reset_again", 32'(ovf), 32'd1);
    chk("ovf_count_8",     32'(count), 32'd8);
    ovf_clr = 1'b1;
    step();
    ovf_clr  = 1'b0;
    in_valid = 1'b0;
    chk("ovf_set_beats_clr", 32'(ovf), 32'd1);
`endif

    drain(8);
    chk("full_drain_count", 32'(count), 32'd0);

    // Reset mid-operation
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_count", 32'(count),     32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    push_byte(8'h44);
    chk("midrst_new_head", 32'(out_data), 32'h44);
    drain(1);

    repeat (3) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
